// File: rtl/heepsilon_pwrgate_ack_if.sv
// Power-gate handshake bundle between x_heep_system (master) and the ack emulator (slave).
interface heepsilon_pwrgate_ack_if #(
    parameter int NUM_DOMAINS = 3
);
    logic [NUM_DOMAINS-1:0] switch_n_i;
    logic [NUM_DOMAINS-1:0] iso_n_i;
    logic                   err_clear_i;
    logic [NUM_DOMAINS-1:0] switch_ack_n_o;
    logic [NUM_DOMAINS-1:0] busy_o;
    logic [NUM_DOMAINS-1:0] seq_err_o;

    modport master (
        output switch_n_i, iso_n_i, err_clear_i,
        input  switch_ack_n_o, busy_o, seq_err_o
    );

    modport slave (
        input  switch_n_i, iso_n_i, err_clear_i,
        output switch_ack_n_o, busy_o, seq_err_o
    );
endinterface

// File: rtl/heepsilon_pwrgate_ack.sv
// Per-domain power switch acknowledge model: each domain ramps off/on with a fixed
// delay, can abort mid-ramp, and flags isolation ordering violations.
module heepsilon_pwrgate_ack #(
    parameter int NUM_DOMAINS = 3,
    parameter int OFF_DELAY   = 16,
    parameter int ON_DELAY    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    heepsilon_pwrgate_ack_if.slave     pg
);

    localparam logic [15:0] OFF_LOAD = 16'(OFF_DELAY - 1);
    localparam logic [15:0] ON_LOAD  = 16'(ON_DELAY - 1);

    typedef enum logic [1:0] {
        ST_ON       = 2'd0,
        ST_RAMP_OFF = 2'd1,
        ST_OFF      = 2'd2,
        ST_RAMP_ON  = 2'd3
    } state_e;

    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
            state_e      state_q;
            logic [15:0] cnt_q;
            logic        ack_q;
            logic        busy_q;
            logic        err_q;
            logic        sw;
            logic        err_set;

            assign sw      = pg.switch_n_i[gi];
            // Anything other than fully powered must already be isolated.
            assign err_set = (state_q != ST_ON) && pg.iso_n_i[gi];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_q <= ST_ON;
                    cnt_q   <= 16'd0;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end else begin
                    err_q <= err_set | (err_q & ~pg.err_clear_i);
                    case (state_q)
                        ST_ON: begin
                            if (sw) begin
                                state_q <= ST_RAMP_OFF;
                                cnt_q   <= OFF_LOAD;
                                busy_q  <= 1'b1;
                            end
                        end
                        ST_RAMP_OFF: begin
                            // Abort is checked first so it wins over completion.
                            if (!sw) begin
                                state_q <= ST_ON;
                                cnt_q   <= 16'd0;
                                busy_q  <= 1'b0;
                            end else if (cnt_q == 16'd0) begin
                                state_q <= ST_OFF;
                                ack_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q - 16'd1;
                            end
                        end
                        ST_OFF: begin
                            if (!sw) begin
                                state_q <= ST_RAMP_ON;
                                cnt_q   <= ON_LOAD;
                                busy_q  <= 1'b1;
                            end
                        end
                        default: begin
                            if (sw) begin
                                state_q <= ST_OFF;
                                cnt_q   <= 16'd0;
                                busy_q  <= 1'b0;
                            end else if (cnt_q == 16'd0) begin
                                state_q <= ST_ON;
                                ack_q   <= 1'b0;
                                busy_q  <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q - 16'd1;
                            end
                        end
                    endcase
                end
            end

            assign pg.switch_ack_n_o[gi] = ack_q;
            assign pg.busy_o[gi]         = busy_q;
            assign pg.seq_err_o[gi]      = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_heepsilon_pwrgate_ack.sv
// Randomized check of two ack emulators (default delays and 1-cycle delays) against a
// per-domain "pending ramp" model.
module tb_heepsilon_pwrgate_ack;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    heepsilon_pwrgate_ack_if #(.NUM_DOMAINS(ND)) if_slow ();
    heepsilon_pwrgate_ack_if #(.NUM_DOMAINS(ND)) if_fast ();

    heepsilon_pwrgate_ack #(.NUM_DOMAINS(ND), .OFF_DELAY(16), .ON_DELAY(32)) u_slow (
        .clk_i(clk), .rst_ni(rst_n), .pg(if_slow.slave)
    );
    heepsilon_pwrgate_ack #(.NUM_DOMAINS(ND), .OFF_DELAY(1), .ON_DELAY(1)) u_fast (
        .clk_i(clk), .rst_ni(rst_n), .pg(if_fast.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Model: ack is the acknowledged power state; a ramp is a pending change with
    // a number of edges still to wait.
    int  off_d[2] = '{16, 1};
    int  on_d[2]  = '{32, 1};
    bit  m_ack[2][ND];
    bit  m_ramp[2][ND];
    int  m_rem[2][ND];
    bit  m_err[2][ND];

    logic [ND-1:0] sw_s, sw_f, iso;
    logic          clr;

    function automatic void model_reset();
        for (int n = 0; n < 2; n++)
            for (int d = 0; d < ND; d++) begin
                m_ack[n][d] = 0; m_ramp[n][d] = 0; m_rem[n][d] = 0; m_err[n][d] = 0;
            end
    endfunction

    function automatic void model_step(input int n, input logic [ND-1:0] sw);
        for (int d = 0; d < ND; d++) begin
            bit set;
            set = iso[d] && (m_ramp[n][d] || m_ack[n][d]);
            m_err[n][d] = set | (m_err[n][d] & ~clr);
            if (!m_ramp[n][d]) begin
                if (sw[d] != m_ack[n][d]) begin
                    m_ramp[n][d] = 1;
                    m_rem[n][d]  = sw[d] ? off_d[n] : on_d[n];
                end
            end else if (sw[d] == m_ack[n][d]) begin
                m_ramp[n][d] = 0;
            end else begin
                m_rem[n][d]--;
                if (m_rem[n][d] == 0) begin
                    m_ack[n][d]  = sw[d];
                    m_ramp[n][d] = 0;
                end
            end
        end
    endfunction

    function automatic logic [ND-1:0] pack(input int n, input int which);
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++)
            v[d] = (which == 0) ? m_ack[n][d] : (which == 1) ? m_ramp[n][d] : m_err[n][d];
        return v;
    endfunction

    task automatic compare_all();
        chk("slow_ack",  32'(if_slow.switch_ack_n_o), 32'(pack(0, 0)));
        chk("slow_busy", 32'(if_slow.busy_o),         32'(pack(0, 1)));
        chk("slow_err",  32'(if_slow.seq_err_o),      32'(pack(0, 2)));
        chk("fast_ack",  32'(if_fast.switch_ack_n_o), 32'(pack(1, 0)));
        chk("fast_busy", 32'(if_fast.busy_o),         32'(pack(1, 1)));
        chk("fast_err",  32'(if_fast.seq_err_o),      32'(pack(1, 2)));
    endtask

    task automatic apply();
        if_slow.switch_n_i = sw_s; if_slow.iso_n_i = iso; if_slow.err_clear_i = clr;
        if_fast.switch_n_i = sw_f; if_fast.iso_n_i = iso; if_fast.err_clear_i = clr;
    endtask

    // One clock: DUT samples the applied inputs, model does the same, then compare.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_step(0, sw_s);
        model_step(1, sw_f);
        compare_all();
    endtask

    initial begin
        sw_s = '0; sw_f = '0; iso = '0; clr = 1'b0;
        apply();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        repeat (2) cycle();

        // Start an off ramp on domain 0, then reset it mid-ramp.
        sw_s = 3'b001; sw_f = 3'b001; iso = 3'b001; apply();
        repeat (8) cycle();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle_reset_hold();
        @(negedge clk);
        rst_n = 1'b1;
        // Request still high: a full ramp must restart after release.
        repeat (20) cycle();

        for (int i = 0; i < 4000; i++) begin
            for (int d = 0; d < ND; d++) begin
                if ($urandom_range(0, 39) == 0) sw_s[d] = ~sw_s[d];
                if (((cyc + d) % 3) == 0) sw_f[d] = ~sw_f[d];
                else if ($urandom_range(0, 9) == 0) sw_f[d] = ~sw_f[d];
            end
            // Short aborts on the slow instance exercise mid-ramp withdrawal.
            if ($urandom_range(0, 199) == 0) sw_s[1] = ~sw_s[1];
            iso = '0;
            for (int d = 0; d < ND; d++)
                if ($urandom_range(0, 24) == 0) iso[d] = 1'b1;
            clr = ($urandom_range(0, 14) == 0);
            apply();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic cycle_reset_hold();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
    endtask

endmodule
